// File: rtl/serial_add_sequencer.sv
// -----------------------------------------------------------------------------
// serial_add_sequencer
//
// Feeds a multi-cycle bit-serial adder and collects its results. Operand
// triples {A, B, Cin} come in on a valid/ready port and are buffered in a
// small FIFO. Adds are launched one at a time with a single-cycle start
// pulse. After a fixed latency the adder's sum and carry are captured and
// presented on a valid/ready output port. Producers and consumers therefore
// never see the adder's serial timing.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   in_valid   in   operand triple offered
//   in_ready   out  FIFO has space (count < DEPTH)
//   in_a/in_b  in   operands, W bits
//   in_cin     in   carry in
//   add_start  out  one-cycle launch pulse to the adder
//   add_a/b    out  registered operands to the adder
//   add_cin    out  registered carry in to the adder
//   add_sum    in   adder sum
//   add_cout   in   adder carry out
//   out_valid  out  result available
//   out_ready  in   consumer accepts the result
//   out_sum    out  captured sum
//   out_cout   out  captured carry out
//   busy       out  FSM is not in IDLE
//   fifo_count out  FIFO occupancy
// -----------------------------------------------------------------------------
module serial_add_sequencer #(
    parameter int W       = 4,
    parameter int DEPTH   = 4,
    parameter int ADD_LAT = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    input  logic                     in_cin,
    output logic                     add_start,
    output logic [W-1:0]             add_a,
    output logic [W-1:0]             add_b,
    output logic                     add_cin,
    input  logic [W-1:0]             add_sum,
    input  logic                     add_cout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_sum,
    output logic                     out_cout,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(ADD_LAT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [W-1:0]  r_mem_a   [DEPTH];
    logic [W-1:0]  r_mem_b   [DEPTH];
    logic          r_mem_cin [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // FSM state and registered outputs
    state_t        r_state;
    logic [LW-1:0] r_lat;
    logic          r_add_start;
    logic [W-1:0]  r_add_a;
    logic [W-1:0]  r_add_b;
    logic          r_add_cin;
    logic          r_out_valid;
    logic [W-1:0]  r_out_sum;
    logic          r_out_cout;
    logic          r_busy;

    logic          w_push;
    logic          w_pop;
    logic          w_not_empty;

    assign in_ready    = (r_count < CW'(DEPTH));
    assign w_push      = in_valid && in_ready;
    assign w_not_empty = (r_count != {CW{1'b0}});

    assign add_start  = r_add_start;
    assign add_a      = r_add_a;
    assign add_b      = r_add_b;
    assign add_cin    = r_add_cin;
    assign out_valid  = r_out_valid;
    assign out_sum    = r_out_sum;
    assign out_cout   = r_out_cout;
    assign busy       = r_busy;
    assign fifo_count = r_count;

    // Pop decision: the FSM takes the head only from IDLE or on a HOLD
    // handshake. Because count is registered, a freshly pushed entry can be
    // popped no earlier than the following edge.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = w_not_empty;
            ST_HOLD: w_pop = out_ready && w_not_empty;
            default: w_pop = 1'b0;
        endcase
    end

    // FIFO storage, pointers and occupancy count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_a[i]   <= {W{1'b0}};
                r_mem_b[i]   <= {W{1'b0}};
                r_mem_cin[i] <= 1'b0;
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem_a[r_wr_ptr]   <= in_a;
                r_mem_b[r_wr_ptr]   <= in_b;
                r_mem_cin[r_wr_ptr] <= in_cin;
                r_wr_ptr            <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencing FSM: pop -> launch pulse -> fixed wait -> hold result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_lat       <= {LW{1'b0}};
            r_add_start <= 1'b0;
            r_add_a     <= {W{1'b0}};
            r_add_b     <= {W{1'b0}};
            r_add_cin   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= {W{1'b0}};
            r_out_cout  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_add_start <= 1'b0;
                    if (w_pop) begin
                        r_add_a     <= r_mem_a[r_rd_ptr];
                        r_add_b     <= r_mem_b[r_rd_ptr];
                        r_add_cin   <= r_mem_cin[r_rd_ptr];
                        r_add_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_LAUNCH;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    // add_start is sampled by the adder on this edge; the
                    // counter then spans the remaining ADD_LAT edges.
                    r_add_start <= 1'b0;
                    r_lat       <= LW'(ADD_LAT - 1);
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_lat == {LW{1'b0}}) begin
                        r_out_sum   <= add_sum;
                        r_out_cout  <= add_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_lat <= r_lat - LW'(1);
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_pop) begin
                            r_add_a     <= r_mem_a[r_rd_ptr];
                            r_add_b     <= r_mem_b[r_rd_ptr];
                            r_add_cin   <= r_mem_cin[r_rd_ptr];
                            r_add_start <= 1'b1;
                            r_state     <= ST_LAUNCH;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_add_start <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sequencer
//
// Directed bench for serial_add_sequencer. A small behavioural adder model
// answers add_start with the true result only during the single cycle before
// the expected capture edge (inverted data otherwise), so a capture on the
// wrong edge shows up as a wrong sum. Expected results are hand-computed.
// -----------------------------------------------------------------------------
module tb_serial_add_sequencer;

    localparam int W       = 4;
    localparam int DEPTH   = 4;
    localparam int ADD_LAT = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         add_start;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;
    logic [2:0]   fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    serial_add_sequencer #(.W(W), .DEPTH(DEPTH), .ADD_LAT(ADD_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .add_start  (add_start),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Adder model: result valid only in the cycle before start_edge+ADD_LAT
    logic [4:0] m_res = 5'd0;
    int         m_cnt = 0;
    always @(posedge clk) begin
        if (add_start) begin
            m_res <= {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
            m_cnt <= ADD_LAT;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign add_sum  = (m_cnt == 1) ? m_res[3:0] : ~m_res[3:0];
    assign add_cout = (m_cnt == 1) ? m_res[4]   : ~m_res[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        in_valid = 1'b1;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic c);
        drive(a, b, c);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!out_valid && k < 60) begin
            tick();
            k++;
        end
        chk({tag, "_valid"}, out_valid, 1);
    endtask

    task automatic wait_result(input string tag, input logic [3:0] s, input logic c);
        wait_valid(tag);
        chk({tag, "_sum"}, out_sum, s);
        chk({tag, "_cout"}, out_cout, c);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drop"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 4'd0;
        in_b      = 4'd0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_add_start", add_start, 0);
        chk("rst_out_sum", out_sum, 0);

        // Single op 5+3+0, exact cycle timing
        push(4'd5, 4'd3, 1'b0);                     // edge 0
        chk("t1_count_after_push", fifo_count, 1);
        chk("t1_no_bypass", add_start, 0);
        tick();                                     // edge 1: pop
        chk("t1_start", add_start, 1);
        chk("t1_add_a", add_a, 5);
        chk("t1_add_b", add_b, 3);
        chk("t1_add_cin", add_cin, 0);
        chk("t1_busy", busy, 1);
        chk("t1_count_after_pop", fifo_count, 0);
        tick();                                     // edge 2
        chk("t1_start_one_cycle", add_start, 0);
        repeat (5) tick();                          // edges 3..7
        chk("t1_not_early", out_valid, 0);
        tick();                                     // edge 8
        chk("t1_valid_edge8", out_valid, 1);
        chk("t1_sum", out_sum, 8);
        chk("t1_cout", out_cout, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_drop", out_valid, 0);
        chk("t1_idle", busy, 0);

        // Overflow cases
        push(4'd15, 4'd1, 1'b1);
        wait_result("ovf1", 4'd1, 1'b1);
        push(4'd15, 4'd15, 1'b1);
        wait_result("ovf2", 4'd15, 1'b1);

        // Fill/stall with out_ready low: five back-to-back pushes
        push(4'd1, 4'd2, 1'b0);
        push(4'd7, 4'd8, 1'b1);
        push(4'd9, 4'd9, 1'b0);
        push(4'd4, 4'd4, 1'b1);
        push(4'd12, 4'd3, 1'b0);
        chk("fill_count", fifo_count, 4);
        chk("fill_in_ready", in_ready, 0);
        drive(4'd6, 4'd6, 1'b1);                    // sixth triple held off
        repeat (3) tick();
        chk("fill_held_count", fifo_count, 4);
        wait_result("fill_r1", 4'd3, 1'b0);
        chk("fill_after_pop_count", fifo_count, 3);
        chk("fill_after_pop_ready", in_ready, 1);
        tick();                                     // sixth triple accepted
        in_valid = 1'b0;
        chk("fill_sixth_count", fifo_count, 4);

        // Backpressure on result 2 for 10 cycles
        wait_valid("bp_r2");
        chk("bp_r2_sum", out_sum, 0);
        chk("bp_r2_cout", out_cout, 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || out_sum != 4'd0 || !out_cout || add_start) seen = 1'b1;
        end
        chk("bp_stable", seen, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_drop", out_valid, 0);
        chk("bp_next_start", add_start, 1);
        chk("bp_next_a", add_a, 9);
        chk("bp_count", fifo_count, 3);

        wait_result("fill_r3", 4'd2, 1'b1);
        chk("pre_sim_count", fifo_count, 2);

        // Simultaneous push with the handshake pop at count=2
        wait_valid("sim_r4");
        chk("sim_r4_sum", out_sum, 9);
        chk("sim_r4_cout", out_cout, 0);
        drive(4'd3, 4'd4, 1'b1);
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("sim_count", fifo_count, 2);
        chk("sim_start", add_start, 1);
        chk("sim_add_a", add_a, 12);

        wait_result("fill_r5", 4'd15, 1'b0);
        wait_result("fill_r6", 4'd13, 1'b0);
        wait_result("sim_r7", 4'd8, 1'b0);
        chk("drain_count", fifo_count, 0);

        // Reset asserted mid-WAIT
        push(4'd2, 4'd2, 1'b0);
        repeat (4) tick();
        chk("rmid_busy_before", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rmid_out_valid", out_valid, 0);
        chk("rmid_out_sum", out_sum, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_add_start", add_start, 0);
        chk("rmid_add_a", add_a, 0);
        chk("rmid_add_b", add_b, 0);
        chk("rmid_count", fifo_count, 0);
        tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
        chk("rmid_no_stale", seen, 0);
        push(4'd6, 4'd3, 1'b1);
        wait_result("rmid_after", 4'd10, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
